// File: rtl/coriolis_ker1_subker0_join.sv
// Join stage for ker1/subker0: pairs in1/in2 in arrival order through 2-entry FIFOs
// and emits in1 +/- in2 on a single registered, back-pressurable output.
module coriolis_ker1_subker0_join #(
    parameter int STREAMW = 32,
    parameter bit SUB     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1,
    input  logic [STREAMW-1:0] in1,
    output logic               iready_in1,
    input  logic               ivalid_in2,
    input  logic [STREAMW-1:0] in2,
    output logic               iready_in2,
    output logic               ovalid,
    output logic [STREAMW-1:0] out1,
    input  logic               oready
);

    logic [STREAMW-1:0] mem1 [2];
    logic [STREAMW-1:0] mem2 [2];
    logic               wptr1, rptr1, wptr2, rptr2;
    logic [1:0]         count1, count2;
    logic               push1, push2;
    logic               slot_free, fire;
    logic [STREAMW-1:0] head1, head2, result;

    // Readies depend only on registered counts (and are forced low while in reset).
    assign iready_in1 = ~rst & (count1 != 2'd2);
    assign iready_in2 = ~rst & (count2 != 2'd2);
    assign push1      = ivalid_in1 & iready_in1;
    assign push2      = ivalid_in2 & iready_in2;

    assign slot_free  = ~ovalid | oready;
    assign fire       = (count1 != 2'd0) & (count2 != 2'd0) & slot_free;

    assign head1      = mem1[rptr1];
    assign head2      = mem2[rptr2];
    assign result     = SUB ? (head1 - head2) : (head1 + head2);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr1  <= 1'b0;
            rptr1  <= 1'b0;
            count1 <= '0;
        end else begin
            if (push1) begin
                mem1[wptr1] <= in1;
                wptr1       <= ~wptr1;
            end
            if (fire) begin
                rptr1 <= ~rptr1;
            end
            case ({push1, fire})
                2'b10:   count1 <= count1 + 2'd1;
                2'b01:   count1 <= count1 - 2'd1;
                default: count1 <= count1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr2  <= 1'b0;
            rptr2  <= 1'b0;
            count2 <= '0;
        end else begin
            if (push2) begin
                mem2[wptr2] <= in2;
                wptr2       <= ~wptr2;
            end
            if (fire) begin
                rptr2 <= ~rptr2;
            end
            case ({push2, fire})
                2'b10:   count2 <= count2 + 2'd1;
                2'b01:   count2 <= count2 - 2'd1;
                default: count2 <= count2;
            endcase
        end
    end

    // Draining clears ovalid but keeps out1 at its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovalid <= 1'b0;
            out1   <= '0;
        end else if (fire) begin
            ovalid <= 1'b1;
            out1   <= result;
        end else if (oready) begin
            ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coriolis_ker1_subker0_join.sv
// Directed bench for coriolis_ker1_subker0_join: one SUB=1 and one SUB=0 instance
// driven by the same streams, with hand-computed expectations.
module tb_coriolis_ker1_subker0_join;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         v1, v2, oready;
    logic [W-1:0] in1, in2;
    logic         r1s, r2s, ovs, r1a, r2a, ova;
    logic [W-1:0] outs, outa;

    always #5 clk = ~clk;

    coriolis_ker1_subker0_join #(.STREAMW(W), .SUB(1'b1)) u_sub (
        .clk(clk), .rst(rst),
        .ivalid_in1(v1), .in1(in1), .iready_in1(r1s),
        .ivalid_in2(v2), .in2(in2), .iready_in2(r2s),
        .ovalid(ovs), .out1(outs), .oready(oready)
    );

    coriolis_ker1_subker0_join #(.STREAMW(W), .SUB(1'b0)) u_add (
        .clk(clk), .rst(rst),
        .ivalid_in1(v1), .in1(in1), .iready_in1(r1a),
        .ivalid_in2(v2), .in2(in2), .iready_in2(r2a),
        .ovalid(ova), .out1(outa), .oready(oready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int waits1 = 0;
    int waits2 = 0;

    logic [W-1:0] got_sub [$];
    logic [W-1:0] got_add [$];
    int           got_cyc [$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_out;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sub;
        logic [W-1:0] exp_add;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sampled mid-cycle: a transfer happens at the next edge when ovalid & oready.
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_ovalid", {31'd0, ovs}, 32'd1);
            check("stall_out1", outs, prev_out);
        end
        prev_stall = !rst && ovs && !oready;
        prev_out   = outs;
        if (!rst && ovs && oready) begin
            got_sub.push_back(outs);
            got_add.push_back(outa);
            got_cyc.push_back(cyc);
        end
    end

    task automatic send1(input logic [W-1:0] d);
        int n = 0;
        in1 = d;
        v1  = 1'b1;
        while (!(r1s && r1a) && n < 200) begin
            tick();
            n++;
            waits1++;
        end
        if (!(r1s && r1a)) check("in1_ready_timeout", {31'd0, r1s}, 32'd1);
        else tick();
        v1 = 1'b0;
    endtask

    task automatic send2(input logic [W-1:0] d);
        int n = 0;
        in2 = d;
        v2  = 1'b1;
        while (!(r2s && r2a) && n < 200) begin
            tick();
            n++;
            waits2++;
        end
        if (!(r2s && r2a)) check("in2_ready_timeout", {31'd0, r2s}, 32'd1);
        else tick();
        v2 = 1'b0;
    endtask

    task automatic clear_results();
        got_sub.delete();
        got_add.delete();
        got_cyc.delete();
    endtask

    task automatic wait_n(input int n);
        int k = 0;
        while (got_sub.size() < n && k < 400) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check("result_count", got_sub.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'd4320,       32'd20,   32'd4300,       32'd4340};
        vecs[1] = '{32'd0,          32'd1,    32'hFFFF_FFFF,  32'd1};
        vecs[2] = '{32'hFFFF_FFFF,  32'd2,    32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'h8000_0000,  32'd1,    32'h7FFF_FFFF,  32'h8000_0001};
        vecs[4] = '{32'd1234,       32'd1234, 32'd0,          32'd2468};

        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; oready = 1'b0; in1 = '0; in2 = '0;
        tick();
        tick();
        check("rst_ovalid", {31'd0, ovs}, 32'd0);
        check("rst_out1", outs, 32'd0);
        check("rst_iready1_low", {31'd0, r1s}, 32'd0);
        check("rst_iready2_low", {31'd0, r2s}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_iready1", {31'd0, r1s}, 32'd1);
        check("post_rst_iready2", {31'd0, r2s}, 32'd1);
        tick();

        // Single pairs: result appears two edges after accept, for one cycle.
        oready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            in1 = vecs[i].a; in2 = vecs[i].b; v1 = 1'b1; v2 = 1'b1;
            tick();
            v1 = 1'b0; v2 = 1'b0;
            check("vec_ovalid_early", {31'd0, ovs}, 32'd0);
            tick();
            check("vec_ovalid_sub", {31'd0, ovs}, 32'd1);
            check("vec_out_sub", outs, vecs[i].exp_sub);
            check("vec_ovalid_add", {31'd0, ova}, 32'd1);
            check("vec_out_add", outa, vecs[i].exp_add);
            tick();
            check("vec_ovalid_drop", {31'd0, ovs}, 32'd0);
        end

        // Skew: in1 leads by two elements and is then back-pressured.
        clear_results();
        in1 = 32'd10; v1 = 1'b1;
        tick();
        in1 = 32'd20;
        tick();
        in1 = 32'd30;
        check("skew_iready1_low", {31'd0, r1s}, 32'd0);
        tick();
        tick();
        check("skew_iready1_held", {31'd0, r1s}, 32'd0);
        check("skew_no_output", {31'd0, ovs}, 32'd0);
        check("skew_iready2_high", {31'd0, r2s}, 32'd1);
        fork
            send1(32'd30);
            begin send2(32'd1); send2(32'd2); send2(32'd3); end
        join
        wait_n(3);
        if (got_sub.size() == 3) begin
            check("skew_sub0", got_sub[0], 32'd9);
            check("skew_sub1", got_sub[1], 32'd18);
            check("skew_sub2", got_sub[2], 32'd27);
            check("skew_add2", got_add[2], 32'd33);
        end

        // Back-pressure: oready low for five cycles mid-stream.
        clear_results();
        fork
            for (int i = 0; i < 8; i++) send1(32'(100 * i + 7));
            for (int i = 0; i < 8; i++) send2(32'(i));
            begin
                repeat (3) tick();
                oready = 1'b0;
                repeat (4) tick();
                check("bp_iready1_low", {31'd0, r1s}, 32'd0);
                check("bp_iready2_low", {31'd0, r2s}, 32'd0);
                check("bp_ovalid_held", {31'd0, ovs}, 32'd1);
                tick();
                oready = 1'b1;
            end
        join
        wait_n(8);
        if (got_sub.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("bp_sub", got_sub[i], 32'(100 * i + 7 - i));
                check("bp_add", got_add[i], 32'(100 * i + 7 + i));
            end
        end

        // Throughput: 100 pairs back to back.
        clear_results();
        waits1 = 0; waits2 = 0;
        fork
            for (int i = 0; i < 100; i++) send1(32'(1000 + 3 * i));
            for (int i = 0; i < 100; i++) send2(32'(7 * i));
        join
        wait_n(100);
        check("tp_waits1", waits1, 32'd0);
        check("tp_waits2", waits2, 32'd0);
        if (got_sub.size() == 100) begin
            check("tp_consecutive", got_cyc[99] - got_cyc[0], 32'd99);
            for (int i = 0; i < 100; i++) begin
                check("tp_sub", got_sub[i], 32'(1000 + 3 * i - 7 * i));
                check("tp_add", got_add[i], 32'(1000 + 3 * i + 7 * i));
            end
        end

        // Mid-operation reset with both FIFOs full and a stalled result.
        clear_results();
        oready = 1'b0;
        fork
            for (int i = 0; i < 3; i++) send1(32'(50 + i));
            for (int i = 0; i < 3; i++) send2(32'(i));
        join
        check("mr_full_iready1", {31'd0, r1s}, 32'd0);
        check("mr_full_iready2", {31'd0, r2s}, 32'd0);
        check("mr_full_ovalid", {31'd0, ovs}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mr_ovalid", {31'd0, ovs}, 32'd0);
        check("mr_out1", outs, 32'd0);
        check("mr_iready1", {31'd0, r1s}, 32'd1);
        check("mr_iready2", {31'd0, r2s}, 32'd1);
        tick();
        clear_results();
        oready = 1'b1;
        fork
            send1(32'd5);
            send2(32'd3);
        join
        wait_n(1);
        if (got_sub.size() == 1) begin
            check("mr_fresh_sub", got_sub[0], 32'd2);
            check("mr_fresh_add", got_add[0], 32'd8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
